// File: rtl/mips_core_pkg.sv
`include "mips_core.svh"
`default_nettype none
// ============================================================================
//  mips_core_pkg
//  Shared types and constants for the core: register image type, the
//  checkpoint recovery FSM state encoding and the default checkpoint depth.
//  Rev 1.0 - initial release
// ============================================================================
package mips_core_pkg;

    localparam int c_data_width         = `DATA_WIDTH;
    localparam int c_num_regs           = 32;
    localparam int c_reg_addr_w         = 5;
    localparam int c_ckpt_depth_default = 4;

    // Full architectural register file image, entry i is register ri.
    typedef logic [c_num_regs-1:0][c_data_width-1:0] reg_image_t;

    // Recovery handshake with the register file.
    typedef enum logic [1:0] {
        CKPT_IDLE    = 2'd0,
        CKPT_ASSERT  = 2'd1,
        CKPT_RELEASE = 2'd2
    } ckpt_state_e;

endpackage
`default_nettype wire

// File: rtl/write_back_ifc.sv
`default_nettype none
// ============================================================================
//  write_back_ifc
//  Writeback bus from the pipeline: a single register write per cycle.
//    uses_rw : write is valid this cycle
//    rw_addr : destination register number
//    rw_data : value being written
//  Rev 1.0 - initial release
// ============================================================================
interface write_back_ifc;
    import mips_core_pkg::*;

    logic                    uses_rw;
    logic [c_reg_addr_w-1:0] rw_addr;
    logic [c_data_width-1:0] rw_data;

    modport in (
        input uses_rw,
        input rw_addr,
        input rw_data
    );

endinterface
`default_nettype wire

// File: rtl/mips_core.svh
`default_nettype none
// ============================================================================
//  mips_core.svh
//  Core-wide macros shared by the register-file and recovery logic.
//  Rev 1.0 - initial release
// ============================================================================
`ifndef MIPS_CORE_SVH
`define MIPS_CORE_SVH

// Width of one architectural register.
`define DATA_WIDTH 32

`endif
`default_nettype wire

// File: rtl/reg_checkpoint_ctrl_ckpt_store.sv
`default_nettype none
// ============================================================================
//  ckpt_store
//  Checkpoint slot storage: DEPTH full register images, one synchronous
//  write port (the allocation tail) and one asynchronous read port (the
//  oldest outstanding checkpoint). Contents are deliberately not reset; a
//  slot is only ever read after it has been written.
//
//  Ports:
//    clk     : clock
//    wr_en   : write wr_data into slot wr_idx on this edge
//    wr_idx  : slot being written
//    wr_data : register image to store
//    rd_idx  : slot being read
//    rd_data : image held in slot rd_idx
//  Rev 1.0 - initial release
// ============================================================================
module ckpt_store
    import mips_core_pkg::*;
#(
    parameter int DEPTH = c_ckpt_depth_default
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  reg_image_t               wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output reg_image_t               rd_data
);

    reg_image_t r_slots [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_slots[wr_idx] <= wr_data;
        end
    end

    assign rd_data = r_slots[rd_idx];

endmodule
`default_nettype wire

// File: rtl/reg_checkpoint_ctrl.sv
`default_nettype none
// ============================================================================
//  reg_checkpoint_ctrl
//  Register-file checkpointing for branch speculation. Every predicted
//  branch captures the architectural register image into a circular buffer
//  of DEPTH slots. A correct resolution frees the oldest slot; a
//  misprediction restores the oldest slot through a two-phase level
//  handshake with the register file and then discards all checkpoints.
//
//  Ports:
//    clk               : clock
//    rst               : synchronous active-high reset
//    take_ckpt         : branch predicted, capture registers
//    resolve_ok        : oldest branch resolved correctly, release its slot
//    mispredict        : oldest branch mispredicted, restore its slot
//    i_wb              : same-cycle writeback, bypassed into the capture
//    regs_in           : live register array
//    recover_snapshot  : level request to load regs_snapshot
//    regs_snapshot     : image being restored
//    recover_done      : register-file acknowledge of recover_snapshot
//    full              : all slots occupied
//    busy              : recovery in progress, front end stalls
//    recovery_complete : single-cycle pulse at end of recovery
//    count             : outstanding checkpoints
//  Rev 1.0 - initial release
// ============================================================================
module reg_checkpoint_ctrl
    import mips_core_pkg::*;
#(
    parameter int DEPTH = c_ckpt_depth_default
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   take_ckpt,
    input  logic                   resolve_ok,
    input  logic                   mispredict,
    write_back_ifc.in              i_wb,
    input  reg_image_t             regs_in,
    output logic                   recover_snapshot,
    output reg_image_t             regs_snapshot,
    input  logic                   recover_done,
    output logic                   full,
    output logic                   busy,
    output logic                   recovery_complete,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    ckpt_state_e        r_state;
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;

    logic       w_idle;
    logic       w_empty;
    logic       w_full;
    logic       w_mispredict_acc;
    logic       w_resolve_acc;
    logic       w_take_acc;
    reg_image_t w_capture;
    reg_image_t w_head_image;

    assign w_idle  = (r_state == CKPT_IDLE);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_cnt_w'(DEPTH));

    // A mispredict wins the cycle: a capture or release arriving alongside
    // it is dropped, since every checkpoint is discarded by the recovery.
    // A mispredict with nothing outstanding is ignored and does not block
    // the other two requests.
    assign w_mispredict_acc = w_idle && mispredict && !w_empty;
    assign w_resolve_acc    = w_idle && !w_mispredict_acc && resolve_ok && !w_empty;
    // Capture is gated on the pre-release count, so take+resolve while full
    // frees a slot but still drops the capture.
    assign w_take_acc       = w_idle && !w_mispredict_acc && take_ckpt && !w_full;

    // The register file has not yet absorbed this cycle's writeback, so the
    // pending write is merged in; r0 is hard-wired zero and written last so
    // a writeback addressed to r0 cannot leak into the image.
    always_comb begin
        w_capture = regs_in;
        if (i_wb.uses_rw) begin
            w_capture[i_wb.rw_addr] = i_wb.rw_data;
        end
        w_capture[0] = '0;
    end

    ckpt_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk     (clk),
        .wr_en   (w_take_acc),
        .wr_idx  (r_tail),
        .wr_data (w_capture),
        .rd_idx  (r_head),
        .rd_data (w_head_image)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= CKPT_IDLE;
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            recover_snapshot  <= 1'b0;
            recovery_complete <= 1'b0;
            regs_snapshot     <= '0;
        end else begin
            recovery_complete <= 1'b0;

            unique case (r_state)
                CKPT_IDLE: begin
                    if (w_mispredict_acc) begin
                        // Snapshot is latched here and left untouched until
                        // the next accepted mispredict.
                        regs_snapshot    <= w_head_image;
                        recover_snapshot <= 1'b1;
                        r_state          <= CKPT_ASSERT;
                    end else begin
                        if (w_take_acc) begin
                            r_tail <= r_tail + c_ptr_w'(1);
                        end
                        if (w_resolve_acc) begin
                            r_head <= r_head + c_ptr_w'(1);
                        end
                        unique case ({w_take_acc, w_resolve_acc})
                            2'b10:   r_count <= r_count + c_cnt_w'(1);
                            2'b01:   r_count <= r_count - c_cnt_w'(1);
                            default: r_count <= r_count;
                        endcase
                    end
                end

                CKPT_ASSERT: begin
                    if (recover_done) begin
                        recover_snapshot <= 1'b0;
                        r_state          <= CKPT_RELEASE;
                    end
                end

                CKPT_RELEASE: begin
                    // Wait for the acknowledge to drop so the register file
                    // is back in its idle phase before new checkpoints start.
                    if (!recover_done) begin
                        recovery_complete <= 1'b1;
                        r_head            <= '0;
                        r_tail            <= '0;
                        r_count           <= '0;
                        r_state           <= CKPT_IDLE;
                    end
                end

                default: begin
                    recover_snapshot <= 1'b0;
                    r_state          <= CKPT_IDLE;
                end
            endcase
        end
    end

    assign count = r_count;
    assign full  = w_full;
    // Stall starts in the very cycle the mispredict is accepted.
    assign busy  = !w_idle || w_mispredict_acc;

endmodule
`default_nettype wire

// File: tb/tb_reg_checkpoint_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_reg_checkpoint_ctrl
//  Self-checking bench for reg_checkpoint_ctrl. A behavioural model of the
//  checkpoint queue pushes the expected restore image onto a scoreboard when
//  a mispredict is driven; the image is popped and compared when the DUT
//  raises recover_snapshot.
//  Rev 1.0 - initial release
// ============================================================================
module tb_reg_checkpoint_ctrl;
    import mips_core_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = c_data_width;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   take_ckpt;
    logic                   resolve_ok;
    logic                   mispredict;
    reg_image_t             regs_in;
    logic                   recover_snapshot;
    reg_image_t             regs_snapshot;
    logic                   recover_done;
    logic                   full;
    logic                   busy;
    logic                   recovery_complete;
    logic [$clog2(DEPTH):0] count;

    write_back_ifc wb_if ();

    reg_checkpoint_ctrl #(
        .DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .take_ckpt         (take_ckpt),
        .resolve_ok        (resolve_ok),
        .mispredict        (mispredict),
        .i_wb              (wb_if),
        .regs_in           (regs_in),
        .recover_snapshot  (recover_snapshot),
        .regs_snapshot     (regs_snapshot),
        .recover_done      (recover_done),
        .full              (full),
        .busy              (busy),
        .recovery_complete (recovery_complete),
        .count             (count)
    );

    always #5 clk = ~clk;

    int         checks    = 0;
    int         failures  = 0;
    int         pulse_cnt = 0;
    reg_image_t model_q [$];
    reg_image_t exp_q   [$];
    bit         m_idle  = 1'b1;
    logic       prev_rs = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic reg_image_t cap_model(input reg_image_t r, input bit u,
                                             input logic [4:0] a, input logic [DW-1:0] d);
        reg_image_t img;
        img = r;
        if (u) img[a] = d;
        img[0] = '0;
        return img;
    endfunction

    task automatic randomize_regs();
        for (int i = 0; i < c_num_regs; i++) regs_in[i] = DW'($urandom);
    endtask

    task automatic set_wb(input bit u, input logic [4:0] a, input logic [DW-1:0] d);
        wb_if.uses_rw = u;
        wb_if.rw_addr = a;
        wb_if.rw_data = d;
    endtask

    // One request cycle: update the model, check the combinational stall,
    // advance past the edge and release the request lines.
    task automatic drive(input bit tk, input bit rs, input bit mp);
        bit exp_busy;
        int sz;
        sz         = model_q.size();
        exp_busy   = !m_idle;
        take_ckpt  = tk;
        resolve_ok = rs;
        mispredict = mp;
        if (m_idle) begin
            if (mp && sz > 0) begin
                exp_q.push_back(model_q[0]);
                m_idle   = 1'b0;
                exp_busy = 1'b1;
            end else begin
                if (rs && sz > 0) void'(model_q.pop_front());
                if (tk && sz < DEPTH)
                    model_q.push_back(cap_model(regs_in, wb_if.uses_rw, wb_if.rw_addr, wb_if.rw_data));
            end
        end
        @(negedge clk);
        chk("busy", busy, exp_busy);
        @(posedge clk); #1;
        take_ckpt     = 1'b0;
        resolve_ok    = 1'b0;
        mispredict    = 1'b0;
        wb_if.uses_rw = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        @(negedge clk);
        chk({tag, "_count"}, count, model_q.size());
        chk({tag, "_full"}, full, model_q.size() == DEPTH);
        @(posedge clk); #1;
    endtask

    // Register-file side of the handshake; acknowledge after 'delay' cycles.
    task automatic recover(input int delay);
        int pc0;
        pc0 = pulse_cnt;
        recover_done = 1'b0;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("hold_rs", recover_snapshot, 1);
            chk("hold_busy", busy, 1);
            @(posedge clk); #1;
        end
        recover_done = 1'b1;
        @(negedge clk);
        chk("ack_rs", recover_snapshot, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_rs", recover_snapshot, 0);
        chk("rel_busy", busy, 1);
        chk("rel_rc", recovery_complete, 0);
        @(posedge clk); #1;
        recover_done = 1'b0;
        @(negedge clk);
        chk("rel_wait_busy", busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rc_pulse", recovery_complete, 1);
        chk("done_busy", busy, 0);
        chk("done_count", count, 0);
        chk("done_full", full, 0);
        @(posedge clk); #1;
        model_q.delete();
        m_idle = 1'b1;
        @(negedge clk);
        chk("rc_single", recovery_complete, 0);
        chk("pulse_cnt", pulse_cnt, pc0 + 1);
        @(posedge clk); #1;
    endtask

    // Scoreboard consumer: each rising recover_snapshot must carry the
    // oldest checkpoint the model held when the mispredict was accepted.
    always @(negedge clk) begin
        reg_image_t img;
        if (recovery_complete === 1'b1) pulse_cnt++;
        if (recover_snapshot === 1'b1 && prev_rs !== 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_recovery", 1, 0);
            end else begin
                img = exp_q.pop_front();
                for (int i = 0; i < c_num_regs; i++)
                    chk($sformatf("snap[%0d]", i), regs_snapshot[i], img[i]);
            end
        end
        prev_rs = recover_snapshot;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int pc0;
        rst          = 1'b1;
        take_ckpt    = 1'b0;
        resolve_ok   = 1'b0;
        mispredict   = 1'b0;
        recover_done = 1'b0;
        set_wb(0, 0, 0);
        randomize_regs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rs", recover_snapshot, 0);
        chk("rst_rc", recovery_complete, 0);
        chk("rst_snap", |regs_snapshot, 0);
        @(posedge clk); #1;

        // Writeback bypass into the capture
        randomize_regs();
        regs_in[5] = 32'h11;
        set_wb(1, 5, 32'hAA);
        drive(1, 0, 0);
        check_counts("bypass_take");
        drive(0, 0, 1);
        recover(1);
        chk("bypass_r5", regs_snapshot[5], 32'hAA);
        chk("bypass_r0", regs_snapshot[0], 0);

        // Fill, overflow, release-while-full, drain, empty corner cases
        for (int i = 0; i < DEPTH; i++) begin
            randomize_regs();
            drive(1, 0, 0);
            check_counts($sformatf("fill%0d", i));
        end
        randomize_regs();
        drive(1, 0, 0);
        check_counts("overflow");
        randomize_regs();
        drive(1, 1, 0);
        check_counts("take_rel_full");
        randomize_regs();
        drive(1, 1, 0);
        check_counts("take_rel_mid");
        for (int i = 0; i < 3; i++) drive(0, 1, 0);
        check_counts("drained");
        drive(0, 1, 0);
        check_counts("rel_empty");
        drive(0, 0, 1);
        @(negedge clk);
        chk("mp_empty_rs", recover_snapshot, 0);
        @(posedge clk); #1;

        // Age order, plus a writeback to r0 that must not appear
        randomize_regs();
        regs_in[1] = 32'd1;
        set_wb(1, 0, 32'h55);
        drive(1, 0, 0);
        randomize_regs();
        regs_in[1] = 32'd2;
        drive(1, 0, 0);
        drive(0, 1, 0);
        drive(0, 0, 1);
        recover(3);
        chk("order_r1", regs_snapshot[1], 2);

        // Mispredict colliding with a take, then a take during ASSERT
        randomize_regs();
        drive(1, 0, 0);
        randomize_regs();
        drive(1, 0, 1);
        randomize_regs();
        drive(1, 0, 0);
        recover(2);
        check_counts("collide_after");

        // Random traffic with wraparound, ending in a recovery
        for (int n = 0; n < 60; n++) begin
            randomize_regs();
            set_wb($urandom_range(0, 1), 5'($urandom_range(0, 31)), DW'($urandom));
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 0);
            check_counts("rand");
        end
        if (model_q.size() == 0) begin
            randomize_regs();
            drive(1, 0, 0);
        end
        drive(0, 0, 1);
        recover(0);

        // Reset while the request is asserted
        randomize_regs();
        drive(1, 0, 0);
        drive(0, 0, 1);
        pc0 = pulse_cnt;
        @(negedge clk);
        chk("abort_pre_rs", recover_snapshot, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_q.delete();
        m_idle = 1'b1;
        @(negedge clk);
        chk("abort_rs", recover_snapshot, 0);
        chk("abort_count", count, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rc", recovery_complete, 0);
        chk("abort_snap", |regs_snapshot, 0);
        @(posedge clk); #1;
        recover_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 recover_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_no_pulse", pulse_cnt, pc0);
        chk("abort_rs_late", recover_snapshot, 0);

        chk("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_checkpoint_ctrl.md
REG_CHECKPOINT_CTRL -- requirements
Module: reg_checkpoint_ctrl

Interface
REQ-001 SHALL have parameter: DEPTH, default 4, number of checkpoint slots (power of two, 2..8).
REQ-002 SHALL have ports, in this order:
  clk  input  1  clock, all state updates on posedge.
  rst  input  1  synchronous, active-high reset.
  take_ckpt  input  1  branch predicted this cycle; capture register state.
  resolve_ok  input  1  oldest outstanding branch resolved correctly; release its checkpoint.
  mispredict  input  1  oldest outstanding branch mispredicted; restore its checkpoint.
  i_wb  write_back_ifc.in  -  same-cycle writeback (uses_rw, rw_addr, rw_data).
  regs_in  input  32 x `DATA_WIDTH  live register array from the register file.
  recover_snapshot  output  1  level request to the register file to load regs_snapshot.
  regs_snapshot  output  32 x `DATA_WIDTH  checkpoint image being restored.
  recover_done  input  1  register-file acknowledge, follows recover_snapshot level.
  full  output  1  all DEPTH slots occupied.
  busy  output  1  recovery in progress; front end stalls.
  recovery_complete  output  1  one-cycle pulse when recovery handshake finishes.
  count  output  $clog2(DEPTH)+1  outstanding checkpoints.

Function
REQ-003 SHALL keep checkpoints in a circular buffer with head (oldest), tail (next free) and count; pointers wrap modulo DEPTH.
REQ-004 SHALL, on take_ckpt with count<DEPTH and state IDLE, write the slot at tail with regs_in, with entry i replaced by i_wb.rw_data when i_wb.uses_rw and rw_addr==i and i!=0.
REQ-005 SHALL force entry 0 of every captured image to '0.
REQ-006 SHALL ignore take_ckpt when count==DEPTH; tail/count unchanged; full stays 1.
REQ-007 SHALL, on resolve_ok with count>0 in IDLE, advance head and decrement count; resolve_ok with count==0 is ignored.
REQ-008 SHALL, on take_ckpt and resolve_ok in the same IDLE cycle with 0<count<DEPTH, perform both; count unchanged. When count==DEPTH, the release takes effect and the capture is dropped.
REQ-009 SHALL ignore mispredict when count==0.
REQ-010 SHALL implement FSM IDLE -> ASSERT -> RELEASE -> IDLE:
  IDLE: on mispredict with count>0, latch the head slot into the regs_snapshot register, go to ASSERT.
  ASSERT: recover_snapshot=1; hold until recover_done==1, then go to RELEASE.
  RELEASE: recover_snapshot=0; hold until recover_done==0, then pulse recovery_complete, clear head/tail/count to 0, go to IDLE.
REQ-011 SHALL give mispredict priority over take_ckpt and resolve_ok in the same cycle; the other two are dropped.
REQ-012 SHALL ignore take_ckpt, resolve_ok and mispredict while not IDLE.
REQ-013 SHALL drive busy=1 in ASSERT and RELEASE, and also in the IDLE cycle in which an accepted mispredict arrives (combinational).
REQ-014 SHALL register recover_snapshot and regs_snapshot; regs_snapshot is stable from the first ASSERT cycle until the next accepted mispredict.
REQ-015 SHALL drive full=(count==DEPTH), combinational from count.

Reset
REQ-016 SHALL, on rst, set state=IDLE, head=tail=count=0, recover_snapshot=0, recovery_complete=0, regs_snapshot='0; full=0 and busy=0 follow.
REQ-017 SHALL abort an in-flight recovery on rst; recover_snapshot drops the next cycle and no recovery_complete pulse is issued.
REQ-018 SHALL leave slot storage contents undefined after reset (not read before written).

Structure
REQ-019 SHALL take `DATA_WIDTH from mips_core.svh; the FSM state enum and the default depth constant belong in the shared mips_core package.
REQ-020 SHALL place slot storage in one sub-module, ckpt_store (one write port at tail, one read port at head).

Verification
REQ-021 Capture with bypass: regs_in[5]=0x11, same cycle wb writes r5=0xAA, take_ckpt; later mispredict -> regs_snapshot[5]=0xAA.
REQ-022 Full: 4 take_ckpt with no resolve -> count=4, full=1; a 5th take -> count stays 4; take+resolve at count=4 -> count=3.
REQ-023 Order: take A (r1=1), take B (r1=2), resolve_ok, mispredict -> regs_snapshot[1]=2; afterwards count=0.
REQ-024 Handshake: recover_done delayed 3 cycles -> recover_snapshot held 3 cycles, busy=1 throughout, exactly one recovery_complete pulse after recover_done falls.
REQ-025 Collision: mispredict+take_ckpt same cycle at count=1 -> take dropped, recovery proceeds; take during ASSERT -> ignored.
REQ-026 Reset mid-recovery: rst in ASSERT -> next cycle recover_snapshot=0, count=0, no recovery_complete pulse.
